// File: rtl/serv_timer.sv
// rtl/serv_timer.sv - machine timer: 64-bit mtime/mtimecmp over a 32-bit Wishbone slave, level mtip
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_wb_cyc             bus request (cycle and strobe combined)
//   i_wb_we              1 = write, 0 = read
//   i_wb_adr[2:0]        word address: 0 mtime lo, 1 mtime hi, 2 mtimecmp lo,
//                        3 mtimecmp hi, 4 CTRL (bit0 EN, [PRE_W+15:16] PRESCALE), 5-7 reserved
//   i_wb_dat[31:0]       write data
//   i_wb_sel[3:0]        byte enables for writes
//   o_wb_dat[31:0]       read data, valid while o_wb_ack
//   o_wb_ack             single-cycle acknowledge
//   o_mtip               registered (mtime >= mtimecmp)
module serv_timer #(
    parameter int PRE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_mtip
);

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [31:0]      shadow_hi;
    logic             en;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pcnt;

    logic             accept;
    logic             wr;
    logic             rd;
    logic             tick;
    logic [63:0]      mtime_next;
    logic [63:0]      mtimecmp_next;
    logic [PRE_W-1:0] prescale_next;
    logic [31:0]      ctrl_rd;
    logic [31:0]      rdata;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? dat[b*8 +: 8] : old[b*8 +: 8];
        end
        return r;
    endfunction

    // Ack blocks the next accept, so a held request is served every other cycle.
    assign accept = i_wb_cyc && !o_wb_ack;
    assign wr     = accept && i_wb_we;
    assign rd     = accept && !i_wb_we;
    assign tick   = en && (pcnt == prescale);

    always_comb begin
        mtime_next    = mtime;
        mtimecmp_next = mtimecmp;
        prescale_next = prescale;
        ctrl_rd       = '0;
        rdata         = '0;

        // A bus write to either mtime half swallows this cycle's tick entirely.
        if (wr && (i_wb_adr == 3'd0 || i_wb_adr == 3'd1)) begin
            if (i_wb_adr == 3'd0) mtime_next[31:0]  = merge(mtime[31:0], i_wb_dat, i_wb_sel);
            else                  mtime_next[63:32] = merge(mtime[63:32], i_wb_dat, i_wb_sel);
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end

        if (wr && i_wb_adr == 3'd2) mtimecmp_next[31:0]  = merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
        if (wr && i_wb_adr == 3'd3) mtimecmp_next[63:32] = merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);

        for (int i = 0; i < PRE_W; i++) begin
            if (wr && i_wb_adr == 3'd4 && i_wb_sel[2 + i/8]) prescale_next[i] = i_wb_dat[16 + i];
        end

        ctrl_rd[0]             = en;
        ctrl_rd[PRE_W+15:16]   = prescale;

        case (i_wb_adr)
            3'd0:    rdata = mtime[31:0];
            3'd1:    rdata = shadow_hi;
            3'd2:    rdata = mtimecmp[31:0];
            3'd3:    rdata = mtimecmp[63:32];
            3'd4:    rdata = ctrl_rd;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            shadow_hi <= '0;
            en        <= 1'b1;
            prescale  <= '0;
            pcnt      <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_dat  <= '0;
            o_mtip    <= 1'b0;
        end else begin
            mtime    <= mtime_next;
            mtimecmp <= mtimecmp_next;
            prescale <= prescale_next;
            if (wr && i_wb_adr == 3'd4 && i_wb_sel[0]) en <= i_wb_dat[0];

            if (wr && i_wb_adr == 3'd4)  pcnt <= '0;
            else if (tick)               pcnt <= '0;
            else if (en)                 pcnt <= pcnt + PRE_W'(1);

            // Latch the pre-increment high word so a following hi read matches this lo value.
            if (rd && i_wb_adr == 3'd0) shadow_hi <= mtime[63:32];

            o_wb_ack <= accept;
            o_wb_dat <= rd ? rdata : 32'd0;
            o_mtip   <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_serv_timer.sv
// tb/tb_serv_timer.sv - directed self-checking bench for serv_timer
module tb_serv_timer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [2:0]  i_wb_adr = 3'd0;
    logic [31:0] i_wb_dat = 32'd0;
    logic [3:0]  i_wb_sel = 4'd0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_mtip;

    int n_checks = 0;
    int n_fail = 0;
    logic mtip_at_ack;

    serv_timer #(.PRE_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(i_wb_cyc), .i_wb_we(i_wb_we),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_mtip(o_mtip)
    );

    always #5 i_clk = ~i_clk;

    // Bus transaction: accept edge, then one idle edge; returns on the negedge after the idle edge.
    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            output logic ok);
        ok = 1'b0;
        i_wb_cyc = 1'b1; i_wb_we = 1'b1; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        for (int i = 0; i < 4; i++) begin
            if (!ok) begin
                @(negedge i_clk);
                if (o_wb_ack) begin
                    ok = 1'b1;
                    mtip_at_ack = o_mtip;
                end
            end
        end
        i_wb_cyc = 1'b0; i_wb_we = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat, output logic ok);
        ok = 1'b0;
        dat = 32'hDEAD_BEEF;
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = adr;
        for (int i = 0; i < 4; i++) begin
            if (!ok) begin
                @(negedge i_clk);
                if (o_wb_ack) begin
                    ok = 1'b1;
                    dat = o_wb_dat;
                end
            end
        end
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic ok;
        int acks;
        repeat (3) @(negedge i_clk);
        n_checks++; if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %0b want 0", o_wb_ack); end
        n_checks++; if (o_wb_dat !== 32'd0) begin n_fail++; $display("FAIL reset_dat got %h want 0", o_wb_dat); end
        n_checks++; if (o_mtip !== 1'b0) begin n_fail++; $display("FAIL reset_mtip got %0b want 0", o_mtip); end
        i_rst_n = 1'b1;
        acks = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_wb_ack) acks++;
        end
        n_checks++; if (acks != 0) begin n_fail++; $display("FAIL idle_ack got %0d acks want 0", acks); end
        wb_read(3'd0, d, ok);
        n_checks++; if (!ok || d !== 32'd10) begin n_fail++; $display("FAIL idle_mtime got %h ok=%0b want 0000000a", d, ok); end
        n_checks++; if (o_mtip !== 1'b0) begin n_fail++; $display("FAIL idle_mtip got %0b want 0", o_mtip); end
    endtask

    task automatic test_prescale;
        logic [31:0] v1, v2, c;
        logic ok1, ok2, ok3;
        wb_write(3'd4, 32'h0003_0001, 4'hF, ok1);
        wb_read(3'd0, v1, ok2);
        repeat (38) @(negedge i_clk);
        wb_read(3'd0, v2, ok3);
        n_checks++; if (!(ok1 && ok2 && ok3) || (v2 - v1) !== 32'd10) begin
            n_fail++; $display("FAIL prescale_delta got %0d want 10", v2 - v1); end
        wb_write(3'd4, 32'h0003_0000, 4'hF, ok1);
        wb_read(3'd0, v1, ok2);
        wb_read(3'd4, c, ok3);
        n_checks++; if (!ok3 || c !== 32'h0003_0000) begin n_fail++; $display("FAIL ctrl_read got %h want 00030000", c); end
        repeat (16) @(negedge i_clk);
        wb_read(3'd0, v2, ok3);
        n_checks++; if (!(ok1 && ok2 && ok3) || v2 !== v1) begin
            n_fail++; $display("FAIL freeze got %h want %h", v2, v1); end
        wb_write(3'd4, 32'h0000_0001, 4'hF, ok1);
    endtask

    task automatic test_mtime_write;
        logic [31:0] d;
        logic ok;
        wb_write(3'd1, 32'h0000_0000, 4'hF, ok);
        wb_write(3'd0, 32'hFFFF_FFFE, 4'hF, ok);
        repeat (2) @(negedge i_clk);
        wb_read(3'd0, d, ok);
        n_checks++; if (!ok || d !== 32'h0000_0001) begin n_fail++; $display("FAIL carry_lo got %h want 00000001", d); end
        wb_write(3'd1, 32'h0000_0005, 4'hF, ok);
        wb_read(3'd1, d, ok);
        n_checks++; if (!ok || d !== 32'h0000_0001) begin n_fail++; $display("FAIL shadow_hi got %h want 00000001", d); end
        wb_write(3'd1, 32'hFFFF_FFFF, 4'hF, ok);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF, ok);
        wb_read(3'd0, d, ok);
        n_checks++; if (!ok || d !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_lo got %h want 00000000", d); end
        wb_read(3'd1, d, ok);
        n_checks++; if (!ok || d !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_hi got %h want 00000000", d); end
    endtask

    task automatic test_mtip;
        logic ok;
        wb_write(3'd2, 32'd20, 4'hF, ok);
        wb_write(3'd3, 32'd0, 4'hF, ok);
        wb_write(3'd0, 32'd0, 4'hF, ok);
        // Here mtime = 1; at each following negedge mtime = j, and mtip reflects mtime one edge earlier.
        for (int j = 2; j <= 24; j++) begin
            @(negedge i_clk);
            n_checks++; if (o_mtip !== (j >= 21)) begin
                n_fail++; $display("FAIL mtip_rise j=%0d got %0b want %0b", j, o_mtip, (j >= 21)); end
        end
        wb_write(3'd3, 32'd1, 4'hF, ok);
        n_checks++; if (!ok || mtip_at_ack !== 1'b1) begin n_fail++; $display("FAIL mtip_hold got %0b want 1", mtip_at_ack); end
        n_checks++; if (o_mtip !== 1'b0) begin n_fail++; $display("FAIL mtip_fall got %0b want 0", o_mtip); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat;
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            pat[k] = o_wb_ack;
        end
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        n_checks++; if (pat !== 4'b0101) begin n_fail++; $display("FAIL back_to_back ack pattern got %b want 0101", pat); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        logic ok;
        wb_write(3'd3, 32'd0, 4'hF, ok);
        n_checks++; if (o_mtip !== 1'b1) begin n_fail++; $display("FAIL pre_reset_mtip got %0b want 1", o_mtip); end
        i_wb_cyc = 1'b1; i_wb_we = 1'b0; i_wb_adr = 3'd0;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_mtip !== 1'b0 || o_wb_ack !== 1'b0 || o_wb_dat !== 32'd0) begin
            n_fail++; $display("FAIL async_reset got mtip=%0b ack=%0b dat=%h want 0/0/0", o_mtip, o_wb_ack, o_wb_dat); end
        @(negedge i_clk);
        n_checks++; if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_no_ack got %0b want 0", o_wb_ack); end
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wb_read(3'd0, d, ok);
        n_checks++; if (!ok || d !== 32'd0) begin n_fail++; $display("FAIL post_reset_mtime got %h want 0", d); end
        wb_read(3'd2, d, ok);
        n_checks++; if (!ok || d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL post_reset_cmp_lo got %h want ffffffff", d); end
        wb_read(3'd3, d, ok);
        n_checks++; if (!ok || d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL post_reset_cmp_hi got %h want ffffffff", d); end
    endtask

    task automatic test_byte_lane;
        logic [31:0] d;
        logic ok;
        wb_write(3'd2, 32'h0000_AB00, 4'b0010, ok);
        wb_read(3'd2, d, ok);
        n_checks++; if (!ok || d !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL byte_lane got %h want ffffabff", d); end
        wb_write(3'd6, 32'hFFFF_FFFF, 4'hF, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reserved_write_ack got 0 want 1"); end
        wb_read(3'd6, d, ok);
        n_checks++; if (!ok || d !== 32'd0) begin n_fail++; $display("FAIL reserved_read got %h want 0", d); end
        wb_read(3'd2, d, ok);
        n_checks++; if (!ok || d !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL reserved_side_effect got %h want ffffabff", d); end
        wb_read(3'd4, d, ok);
        n_checks++; if (!ok || d !== 32'h0000_0001) begin n_fail++; $display("FAIL ctrl_reset got %h want 00000001", d); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_mtime_write();
        test_mtip();
        test_back_to_back();
        test_async_reset();
        test_byte_lane();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
